// File: rtl/codec_ctrl_arbiter.sv
// rtl/codec_ctrl_arbiter.sv - round-robin arbiter sharing the codec SPI write path and CS latch pulse
module codec_ctrl_arbiter #(
  parameter int NREQ          = 4,
  parameter int CS_LOW_CYCLES = 4,
  parameter int GAP_CYCLES    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NREQ-1:0]         req,
  input  logic [7*NREQ-1:0]       req_addr,
  input  logic [9*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [15:0]             spi_data,
  output logic                    spi_trg,
  input  logic                    spi_rdy,
  output logic                    cs
);

  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (CS_LOW_CYCLES > GAP_CYCLES) ? CS_LOW_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [IW-1:0] LAST_REQ = IW'(NREQ - 1);
  localparam logic [CW-1:0] CS_LAST  = CW'(CS_LOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE,
    LATCH,
    GAP
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] cnt;

  logic          any_req;
  logic          hi_found;
  logic [IW-1:0] hi_win;
  logic [IW-1:0] lo_win;
  logic [IW-1:0] winner;
  logic [6:0]    win_addr;
  logic [8:0]    win_data;

  // Lowest requester above rr_ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req = 1'b1;
        lo_win  = IW'(i);
        if (IW'(i) > rr_ptr) begin
          hi_found = 1'b1;
          hi_win   = IW'(i);
        end
      end
    end
    winner = hi_found ? hi_win : lo_win;
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IW'(i)) begin
        win_addr = req_addr[7*i +: 7];
        win_data = req_data[9*i +: 9];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= LAST_REQ;
      cnt      <= '0;
      grant_id <= '0;
      spi_data <= '0;
      spi_trg  <= 1'b0;
      busy     <= 1'b0;
      cs       <= 1'b1;
      ack      <= '0;
    end else begin
      spi_trg <= 1'b0;
      ack     <= '0;
      unique case (state)
        IDLE: begin
          if (enable && spi_rdy && any_req) begin
            rr_ptr   <= winner;
            grant_id <= winner;
            spi_data <= {win_addr, win_data};
            busy     <= 1'b1;
            spi_trg  <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (!spi_rdy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (spi_rdy) begin
            cs    <= 1'b0;
            cnt   <= '0;
            state <= LATCH;
          end
        end
        LATCH: begin
          if (cnt == CS_LAST) begin
            cs            <= 1'b1;
            ack[grant_id] <= 1'b1;
            cnt           <= '0;
            state         <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  ack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(ack));
  trg_needs_rdy: assert property (@(posedge clk) disable iff (reset)
    (state == IDLE && !spi_rdy) |=> !spi_trg);

endmodule
